// File: rtl/ila_window_capture_pkg.sv
// -----------------------------------------------------------------------------
// ila_window_capture_pkg
// Shared definitions for the ILA window capture engine:
//   - capture FSM state encoding (visible on the state output)
//   - trigger reduction / trigger type selectors
//   - helpers that size the readout word select
// -----------------------------------------------------------------------------
package ila_window_capture_pkg;

  // Capture FSM states; the numeric values are software visible.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } ila_state_e;

  // Reduction applied over the participating trigger bits.
  localparam logic ILA_REDUCE_OR  = 1'b0;
  localparam logic ILA_REDUCE_AND = 1'b1;

  // Per-bit trigger type.
  localparam logic ILA_TRIG_LEVEL = 1'b0;
  localparam logic ILA_TRIG_EDGE  = 1'b1;

  // Number of DATA_W words needed to cover one sample (at least one).
  function automatic int ila_num_words(input int signal_w, input int data_w);
    int n;
    n = (signal_w + data_w - 32'sd1) / data_w;
    if (n < 32'sd1) begin
      n = 32'sd1;
    end else begin
      n = n;
    end
    return n;
  endfunction

  // Width of the word-select field: max(1, clog2(words per sample)).
  function automatic int ila_sel_w(input int signal_w, input int data_w);
    int n;
    n = ila_num_words(signal_w, data_w);
    if (n <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/ila_window_capture_if.sv
// -----------------------------------------------------------------------------
// ila_window_capture_if
// Readout / status bus between the ILA register front-end (master) and the
// capture engine (slave).
//   rd_index   master->slave  window index, 0 = oldest sample
//   rd_select  master->slave  DATA_W slice of the selected sample
//   rd_value   slave->master  selected slice, one cycle after index/select
//   state      slave->master  capture FSM state
//   done       slave->master  window complete and frozen
//   n_samples  slave->master  samples in the window (0 until done)
//   trig_index slave->master  window index of the trigger sample
// -----------------------------------------------------------------------------
interface ila_window_capture_if #(
  parameter int BUFFER_W = 10,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 1
);

  logic [BUFFER_W-1:0] rd_index;
  logic [SEL_W-1:0]    rd_select;
  logic [DATA_W-1:0]   rd_value;
  logic [2:0]          state;
  logic                done;
  logic [BUFFER_W:0]   n_samples;
  logic [BUFFER_W-1:0] trig_index;

  modport master (
    output rd_index,
    output rd_select,
    input  rd_value,
    input  state,
    input  done,
    input  n_samples,
    input  trig_index
  );

  modport slave (
    input  rd_index,
    input  rd_select,
    output rd_value,
    output state,
    output done,
    output n_samples,
    output trig_index
  );

endinterface

// File: rtl/ila_window_capture_trigger_match.sv
// -----------------------------------------------------------------------------
// ila_window_capture_trigger_match
// Vectorised trigger matcher. Each bit is optionally inverted, then judged as
// a level or a rising edge against the value seen on the previous qualified
// sample; the masked-in bits are reduced with OR or AND.
//   clk, rst          clock, asynchronous active-high reset
//   sample_en_i       qualifies this cycle's sample
//   trigger_i         raw trigger inputs
//   mask_i            1 = bit participates
//   type_i            0 = level, 1 = rising edge
//   negate_i          invert bit before the type logic
//   reduce_type_i     0 = OR, 1 = AND
//   force_trigger_i   unconditional hit
//   hit_o             combinational hit for this cycle
// -----------------------------------------------------------------------------
module ila_window_capture_trigger_match
  import ila_window_capture_pkg::*;
#(
  parameter int TRIGGER_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en_i,
  input  logic [TRIGGER_W-1:0] trigger_i,
  input  logic [TRIGGER_W-1:0] mask_i,
  input  logic [TRIGGER_W-1:0] type_i,
  input  logic [TRIGGER_W-1:0] negate_i,
  input  logic                 reduce_type_i,
  input  logic                 force_trigger_i,
  output logic                 hit_o
);

  logic [TRIGGER_W-1:0] t_d;
  logic [TRIGGER_W-1:0] prev_t_q;
  logic [TRIGGER_W-1:0] bit_hit_s;
  logic                 any_s;
  logic                 all_s;
  logic                 reduced_s;

  // Per-bit evaluation and reduction over the participating bits.
  always_comb begin
    t_d       = trigger_i ^ negate_i;
    bit_hit_s = '0;
    for (int b = 0; b < TRIGGER_W; b++) begin
      if (type_i[b] == ILA_TRIG_LEVEL) begin
        bit_hit_s[b] = t_d[b];
      end else begin
        bit_hit_s[b] = t_d[b] & ~prev_t_q[b];
      end
    end
    any_s = |(bit_hit_s & mask_i);
    // An empty mask must never fire, even though AND over nothing is true.
    all_s = (&(bit_hit_s | ~mask_i)) & (|mask_i);
    case (reduce_type_i)
      ILA_REDUCE_OR:  reduced_s = any_s;
      ILA_REDUCE_AND: reduced_s = all_s;
      default:        reduced_s = 1'b0;
    endcase
    hit_o = force_trigger_i | (sample_en_i & reduced_s);
  end

  // Edge history follows every qualified sample, whatever the capture state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_t_q <= '0;
    end else if (sample_en_i) begin
      prev_t_q <= t_d;
    end else begin
      prev_t_q <= prev_t_q;
    end
  end

endmodule

// File: rtl/ila_window_capture.sv
// -----------------------------------------------------------------------------
// ila_window_capture
// Capture engine: samples SIGNAL_W-bit data into a circular buffer of
// 2^BUFFER_W entries, keeps a pre-trigger and post-trigger window around one
// trigger event, then freezes the buffer for oldest-first readback.
//   clk, rst              clock, asynchronous active-high reset
//   sample_en_i           qualifies a sample this cycle
//   signal_i              data to capture
//   trigger_i             raw trigger inputs
//   trigger_mask_i        1 = trigger bit participates
//   trigger_type_i        0 = level, 1 = rising edge (after negate)
//   negate_trigger_i      invert trigger bit before type logic
//   reduce_type_i         0 = OR, 1 = AND over participating bits
//   force_trigger_i       one-cycle forced trigger
//   pre_samples_i         samples kept before the trigger (latched at arm)
//   post_samples_i        samples kept after the trigger (clipped at arm)
//   arm_i / abort_i       start capture / return to idle (abort wins)
//   rd_if (slave)         readout index/select, registered slice, status
// -----------------------------------------------------------------------------
module ila_window_capture
  import ila_window_capture_pkg::*;
#(
  parameter int SIGNAL_W  = 64,
  parameter int DATA_W    = 32,
  parameter int BUFFER_W  = 10,
  parameter int TRIGGER_W = 4,
  parameter int SEL_W     = ila_sel_w(SIGNAL_W, DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en_i,
  input  logic [SIGNAL_W-1:0]  signal_i,
  input  logic [TRIGGER_W-1:0] trigger_i,
  input  logic [TRIGGER_W-1:0] trigger_mask_i,
  input  logic [TRIGGER_W-1:0] trigger_type_i,
  input  logic [TRIGGER_W-1:0] negate_trigger_i,
  input  logic                 reduce_type_i,
  input  logic                 force_trigger_i,
  input  logic [BUFFER_W-1:0]  pre_samples_i,
  input  logic [BUFFER_W-1:0]  post_samples_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  ila_window_capture_if.slave  rd_if
);

  localparam int DEPTH  = 1 << BUFFER_W;
  localparam int NWORDS = ila_num_words(SIGNAL_W, DATA_W);
  localparam int EXT_W  = NWORDS * DATA_W;
  localparam logic [BUFFER_W-1:0] ONE_B = {{(BUFFER_W-1){1'b0}}, 1'b1};

  // Capture state
  ila_state_e          state_q;
  logic [BUFFER_W-1:0] wr_ptr_q;
  logic [BUFFER_W-1:0] pre_cnt_q;
  logic [BUFFER_W-1:0] post_cnt_q;
  logic [BUFFER_W-1:0] p_q;
  logic [BUFFER_W-1:0] q_q;
  logic [BUFFER_W-1:0] trig_addr_q;
  logic                done_q;
  logic [BUFFER_W:0]   n_samples_q;
  logic [BUFFER_W-1:0] trig_index_q;
  logic [DATA_W-1:0]   rd_value_q;

  // Sample storage (two-port: one write, one read)
  logic [SIGNAL_W-1:0] mem_q [0:DEPTH-1];

  logic                hit_s;
  logic [BUFFER_W-1:0] room_s;
  logic [BUFFER_W-1:0] q_clip_s;
  logic [BUFFER_W:0]   win_len_s;
  logic                capturing_s;
  logic                wr_en_s;
  logic [BUFFER_W-1:0] rd_addr_s;
  logic [SIGNAL_W-1:0] rd_word_s;
  logic [EXT_W-1:0]    ext_s;
  logic [DATA_W-1:0]   slice_s;

  ila_window_capture_trigger_match #(
    .TRIGGER_W (TRIGGER_W)
  ) u_trigger_match (
    .clk             (clk),
    .rst             (rst),
    .sample_en_i     (sample_en_i),
    .trigger_i       (trigger_i),
    .mask_i          (trigger_mask_i),
    .type_i          (trigger_type_i),
    .negate_i        (negate_trigger_i),
    .reduce_type_i   (reduce_type_i),
    .force_trigger_i (force_trigger_i),
    .hit_o           (hit_s)
  );

  // Post-trigger clipping so the whole window always fits in the buffer.
  always_comb begin
    room_s = {BUFFER_W{1'b1}} - pre_samples_i;  // D-1-P, never negative
    if (post_samples_i > room_s) begin
      q_clip_s = room_s;
    end else begin
      q_clip_s = post_samples_i;
    end
    win_len_s = {1'b0, p_q} + {1'b0, q_q} + {{BUFFER_W{1'b0}}, 1'b1};
  end

  // Write qualification: only the three capturing states store samples.
  always_comb begin
    if ((state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST)) begin
      capturing_s = 1'b1;
    end else begin
      capturing_s = 1'b0;
    end
    wr_en_s = sample_en_i & capturing_s & ~abort_i;
  end

  // Capture FSM with all status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      p_q          <= '0;
      q_q          <= '0;
      trig_addr_q  <= '0;
      done_q       <= 1'b0;
      n_samples_q  <= '0;
      trig_index_q <= '0;
    end else if (abort_i) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      n_samples_q  <= '0;
      trig_index_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            done_q       <= 1'b0;
            n_samples_q  <= '0;
            trig_index_q <= '0;
            p_q          <= pre_samples_i;
            q_q          <= q_clip_s;
            // With no pre-trigger history the very next sample may trigger.
            if (pre_samples_i == '0) begin
              state_q <= ST_WAIT;
            end else begin
              state_q <= ST_PRE;
            end
          end else begin
            state_q <= state_q;
          end
        end
        ST_PRE: begin
          if (sample_en_i) begin
            wr_ptr_q  <= wr_ptr_q + ONE_B;
            pre_cnt_q <= pre_cnt_q + ONE_B;
            if (pre_cnt_q == (p_q - ONE_B)) begin
              state_q <= ST_WAIT;
            end else begin
              state_q <= ST_PRE;
            end
          end else begin
            state_q <= ST_PRE;
          end
        end
        ST_WAIT: begin
          if (sample_en_i) begin
            wr_ptr_q <= wr_ptr_q + ONE_B;
            if (hit_s) begin
              trig_addr_q <= wr_ptr_q;
              if (q_q == '0) begin
                state_q      <= ST_DONE;
                done_q       <= 1'b1;
                n_samples_q  <= win_len_s;
                trig_index_q <= p_q;
              end else begin
                state_q <= ST_POST;
              end
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_POST: begin
          if (sample_en_i) begin
            wr_ptr_q   <= wr_ptr_q + ONE_B;
            post_cnt_q <= post_cnt_q + ONE_B;
            if (post_cnt_q == (q_q - ONE_B)) begin
              state_q      <= ST_DONE;
              done_q       <= 1'b1;
              n_samples_q  <= win_len_s;
              trig_index_q <= p_q;
            end else begin
              state_q <= ST_POST;
            end
          end else begin
            state_q <= ST_POST;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sample buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= signal_i;
    end
  end

  // Readout addressing: window index 0 is P samples before the trigger.
  always_comb begin
    rd_addr_s = trig_addr_q - p_q + rd_if.rd_index;
    rd_word_s = mem_q[rd_addr_s];
    ext_s     = '0;
    ext_s[SIGNAL_W-1:0] = rd_word_s;
    slice_s   = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (rd_if.rd_select == w[SEL_W-1:0]) begin
        slice_s = ext_s[w*DATA_W +: DATA_W];
      end else begin
        slice_s = slice_s;
      end
    end
  end

  // Registered readout slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_value_q <= '0;
    end else begin
      rd_value_q <= slice_s;
    end
  end

  assign rd_if.rd_value   = rd_value_q;
  assign rd_if.state      = state_q;
  assign rd_if.done       = done_q;
  assign rd_if.n_samples  = n_samples_q;
  assign rd_if.trig_index = trig_index_q;

endmodule

// File: tb/tb_ila_window_capture.sv
// -----------------------------------------------------------------------------
// tb_ila_window_capture
// Directed and randomized stimulus for ila_window_capture (D = 16). The
// reference keeps every sample written since arm in a queue; the trigger is
// the first hit at queue position >= P and the window is queue[k-P .. k+Q].
// -----------------------------------------------------------------------------
module tb_ila_window_capture;

  localparam int SW = 64;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_en = 1'b0;
  logic [SW-1:0] signal = '0;
  logic [TW-1:0] trigger = '0;
  logic [TW-1:0] trigger_mask = '0;
  logic [TW-1:0] trigger_type = '0;
  logic [TW-1:0] negate_trigger = '0;
  logic          reduce_type = 1'b0;
  logic          force_trigger = 1'b0;
  logic [BW-1:0] pre_samples = '0;
  logic [BW-1:0] post_samples = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;

  always #5 clk = ~clk;

  ila_window_capture_if #(.BUFFER_W(BW), .DATA_W(DW), .SEL_W(1)) rif ();

  ila_window_capture #(
    .SIGNAL_W(SW), .DATA_W(DW), .BUFFER_W(BW), .TRIGGER_W(TW), .SEL_W(1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_en_i      (sample_en),
    .signal_i         (signal),
    .trigger_i        (trigger),
    .trigger_mask_i   (trigger_mask),
    .trigger_type_i   (trigger_type),
    .negate_trigger_i (negate_trigger),
    .reduce_type_i    (reduce_type),
    .force_trigger_i  (force_trigger),
    .pre_samples_i    (pre_samples),
    .post_samples_i   (post_samples),
    .arm_i            (arm),
    .abort_i          (abort),
    .rd_if            (rif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [SW-1:0] hist [$];
  int            m_p = 0;
  int            m_q = 0;
  int            m_k = -1;
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  logic [TW-1:0] m_prev = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input bit en, input logic [TW-1:0] trg, input bit frc);
    bit any_h = 1'b0;
    bit all_h = 1'b1;
    bit t;
    bit bh;
    if (frc) return 1'b1;
    if (!en || trigger_mask == '0) return 1'b0;
    for (int b = 0; b < TW; b++) begin
      if (trigger_mask[b]) begin
        t  = trg[b] ^ negate_trigger[b];
        bh = trigger_type[b] ? (t && !m_prev[b]) : t;
        any_h = any_h | bh;
        all_h = all_h & bh;
      end
    end
    return reduce_type ? all_h : any_h;
  endfunction

  function automatic int exp_state();
    if (m_done) return 4;
    if (!m_active) return 0;
    if (hist.size() < m_p) return 1;
    if (m_k < 0) return 2;
    return 3;
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_state"}, 64'(rif.state), 64'(exp_state()));
    check({tag, "_done"}, 64'(rif.done), 64'(m_done));
    check({tag, "_nsamp"}, 64'(rif.n_samples), m_done ? 64'(m_p + 1 + m_q) : 64'd0);
    if (m_done) begin
      check({tag, "_tidx"}, 64'(rif.trig_index), 64'(m_p));
    end
  endtask

  // One clock: drive, take the edge, update the reference, compare status.
  task automatic step(input bit en, input logic [SW-1:0] sig, input logic [TW-1:0] trg,
                      input bit frc, input bit armv, input bit abtv);
    bit h;
    int idx;
    sample_en = en; signal = sig; trigger = trg;
    force_trigger = frc; arm = armv; abort = abtv;
    @(posedge clk);
    #1;
    h = model_hit(en, trg, frc);
    if (abtv) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (armv && !m_active) begin
      m_p = int'(pre_samples);
      m_q = int'(post_samples);
      if (m_q > D - 1 - m_p) m_q = D - 1 - m_p;
      hist.delete();
      m_k = -1;
      m_active = 1'b1;
      m_done = 1'b0;
    end else if (m_active && en) begin
      hist.push_back(sig);
      idx = hist.size() - 1;
      if (m_k < 0 && idx >= m_p && h) m_k = idx;
      if (m_k >= 0 && idx == m_k + m_q) begin
        m_active = 1'b0;
        m_done = 1'b1;
      end
    end
    if (en) m_prev = trg ^ negate_trigger;
    sample_en = 1'b0; force_trigger = 1'b0; arm = 1'b0; abort = 1'b0;
    check_status("step");
  endtask

  task automatic readback(input string tag);
    int len = m_p + 1 + m_q;
    logic [63:0] e;
    for (int i = 0; i < len; i++) begin
      for (int s = 0; s < 2; s++) begin
        rif.rd_index  = i[BW-1:0];
        rif.rd_select = s[0];
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        e = hist[m_k - m_p + i];
        e = (s == 0) ? {32'h0, e[31:0]} : {32'h0, e[63:32]};
        check(tag, 64'(rif.rd_value), e);
      end
    end
  endtask

  initial begin
    logic [TW-1:0] seq4 [12];
    int e_cnt;
    bit en;
    rif.rd_index  = '0;
    rif.rd_select = 1'b0;

    // Reset
    #1 rst = 1'b1;
    #3;
    check("rst_state", 64'(rif.state), 64'd0);
    check("rst_done", 64'(rif.done), 64'd0);
    check("rst_nsamp", 64'(rif.n_samples), 64'd0);
    check("rst_tidx", 64'(rif.trig_index), 64'd0);
    check("rst_rdval", 64'(rif.rd_value), 64'd0);
    #7 rst = 1'b0;

    // 1: level trigger bit0 at sample 10, P=3 Q=4
    trigger_mask = 4'b0001; trigger_type = 4'b0000; negate_trigger = 4'b0000;
    reduce_type = 1'b0; pre_samples = 4'd3; post_samples = 4'd4;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 15; c++) begin
      step(1'b1, {$urandom(), c[31:0]}, (c == 10) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    check("t1_state", 64'(rif.state), 64'd4);
    check("t1_nsamp", 64'(rif.n_samples), 64'd8);
    check("t1_tidx", 64'(rif.trig_index), 64'd3);
    readback("t1_rd");
    rif.rd_index = 4'd3; rif.rd_select = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("t1_trig_sample", 64'(rif.rd_value), 64'd10);

    // 2: rising edge, trigger already high before arm, rise at sample 20
    trigger_type = 4'b0001;
    step(1'b1, '0, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, '0, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 4'b0001, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 25; c++) begin
      step(1'b1, {$urandom(), c[31:0]}, (c == 18 || c == 19) ? 4'b0000 : 4'b0001,
           1'b0, 1'b0, 1'b0);
    end
    readback("t2_rd");
    rif.rd_index = 4'd3; rif.rd_select = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("t2_trig_sample", 64'(rif.rd_value), 64'd20);

    // 3: P=12, Q=10 clipped to 3, window wraps the buffer
    trigger_type = 4'b0000; pre_samples = 4'd12; post_samples = 4'd10;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 29; c++) begin
      step(1'b1, {$urandom(), $urandom()}, (c == 25) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    check("t3_nsamp", 64'(rif.n_samples), 64'd16);
    check("t3_tidx", 64'(rif.trig_index), 64'd12);
    readback("t3_rd");

    // 4: hits during PRE ignored; AND over mask 0101
    seq4 = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001,
             4'b0001, 4'b0100, 4'b0110, 4'b1101, 4'b0000, 4'b0000};
    trigger_mask = 4'b0101; reduce_type = 1'b1; pre_samples = 4'd5; post_samples = 4'd2;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step(1'b1, {$urandom(), c[31:0]}, seq4[c], 1'b0, 1'b0, 1'b0);
    end
    readback("t4_rd");
    rif.rd_index = 4'd5; rif.rd_select = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("t4_trig_sample", 64'(rif.rd_value), 64'd9);

    // 5: abort in POST, then P=0 Q=0 with force_trigger
    trigger_mask = 4'b0001; reduce_type = 1'b0; pre_samples = 4'd2; post_samples = 4'd6;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, {$urandom(), $urandom()}, (c == 3) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    check("t5_in_post", 64'(rif.state), 64'd3);
    step(1'b1, {$urandom(), $urandom()}, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("t5_abort_state", 64'(rif.state), 64'd0);
    check("t5_abort_done", 64'(rif.done), 64'd0);
    trigger_mask = 4'b0000; pre_samples = 4'd0; post_samples = 4'd0;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, {$urandom(), $urandom()}, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("t5_nsamp", 64'(rif.n_samples), 64'd1);
    readback("t5_rd");

    // 6a: alternating sample_en, random triggers on negated edge of bit1
    trigger_mask = 4'b0010; negate_trigger = 4'b0010; trigger_type = 4'b0010;
    reduce_type = 1'b0; pre_samples = 4'd4; post_samples = 4'd4;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 300 && !m_done; c++) begin
      en = (c % 2) == 0;
      step(en, {$urandom(), $urandom()}, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    end
    check("t6_done_state", 64'(rif.state), 64'd4);
    if (m_done) readback("t6_rd");

    // 6b: asynchronous reset in the middle of POST
    trigger_mask = 4'b0001; negate_trigger = 4'b0000; trigger_type = 4'b0000;
    pre_samples = 4'd3; post_samples = 4'd5;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    e_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      en = (c % 2) == 0;
      step(en, {$urandom(), $urandom()}, (en && e_cnt == 4) ? 4'b0001 : 4'b0000,
           1'b0, 1'b0, 1'b0);
      if (en) e_cnt++;
    end
    check("t6b_in_post", 64'(rif.state), 64'd3);
    #2 rst = 1'b1;
    #1;
    m_active = 1'b0; m_done = 1'b0; m_prev = '0;
    check("t6b_rst_state", 64'(rif.state), 64'd0);
    check("t6b_rst_done", 64'(rif.done), 64'd0);
    check("t6b_rst_nsamp", 64'(rif.n_samples), 64'd0);
    check("t6b_rst_tidx", 64'(rif.trig_index), 64'd0);
    check("t6b_rst_rdval", 64'(rif.rd_value), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, {$urandom(), $urandom()}, 4'b0001, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
